// File: rtl/cam_match_encoder_if.sv
// Handshake bundle between a CAM lookup port, the match encoder and its hit consumer.
// master = lookup/consumer side, slave = encoder side.
interface cam_match_encoder_if #(
    parameter int ADDR_WIDTH = 4
);
    logic                    match_valid;
    logic [2**ADDR_WIDTH-1:0] match_vec;
    logic                    match_ready;
    logic                    hit_valid;
    logic                    hit_ready;
    logic [ADDR_WIDTH-1:0]   hit_addr;
    logic                    hit_last;
    logic                    miss;
    logic [ADDR_WIDTH:0]     match_count;

    modport master (
        output match_valid, match_vec, hit_ready,
        input  match_ready, hit_valid, hit_addr, hit_last, miss, match_count
    );

    modport slave (
        input  match_valid, match_vec, hit_ready,
        output match_ready, hit_valid, hit_addr, hit_last, miss, match_count
    );
endinterface

// File: rtl/cam_match_encoder.sv
// Serialises a CAM match bitmap into one hit address per cycle, lowest address first.
// Optional macro CAM_MATCH_COUNT_EN adds a registered popcount of each accepted vector.
//
// state | meaning
// IDLE  | ready for a new match vector; hit outputs held at 0
// EMIT  | presenting the lowest set bit of pending until the last one is taken
module cam_match_encoder #(
    parameter int ADDR_WIDTH = 4
) (
    input  logic clk,
    input  logic rst,
    cam_match_encoder_if.slave bus
);
    localparam int VEC_W = 2**ADDR_WIDTH;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_EMIT = 1'b1;

    logic [0:0]            r_state;
    logic [VEC_W-1:0]      r_pending;
    logic                  r_miss;

    logic [ADDR_WIDTH-1:0] w_low_addr;
    logic [VEC_W-1:0]      w_pending_next;
    logic                  w_single;
    logic                  w_accept;
    logic                  w_emit;

    always_comb begin
        w_low_addr = '0;
        for (int i = VEC_W - 1; i >= 0; i--) begin
            if (r_pending[i]) begin
                w_low_addr = ADDR_WIDTH'(i);
            end
        end
    end

    // x & (x-1) drops exactly the lowest set bit, i.e. the one at w_low_addr.
    assign w_pending_next = r_pending & (r_pending - VEC_W'(1));
    assign w_single       = (r_pending != '0) && (w_pending_next == '0);
    assign w_emit         = (r_state == ST_EMIT);
    assign w_accept       = bus.match_valid && (r_state == ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_pending <= '0;
            r_miss    <= 1'b0;
        end else begin
            r_miss <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_pending <= bus.match_vec;
                        if (bus.match_vec != '0) begin
                            r_state <= ST_EMIT;
                        end else begin
                            r_miss <= 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    if (bus.hit_ready) begin
                        r_pending <= w_pending_next;
                        if (w_single) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.match_ready = (r_state == ST_IDLE);
    assign bus.hit_valid   = w_emit;
    assign bus.hit_addr    = w_emit ? w_low_addr : '0;
    assign bus.hit_last    = w_emit && w_single;
    assign bus.miss        = r_miss;

`ifdef CAM_MATCH_COUNT_EN
    logic [ADDR_WIDTH:0] r_count;
    logic [ADDR_WIDTH:0] w_popcount;

    always_comb begin
        w_popcount = '0;
        for (int i = 0; i < VEC_W; i++) begin
            w_popcount = w_popcount + (ADDR_WIDTH + 1)'(bus.match_vec[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= w_popcount;
        end
    end

    assign bus.match_count = r_count;
`else
    assign bus.match_count = '0;
`endif
endmodule
